atpg_tester: RTL
================

# atpg_tester

Sequential stuck-at test controller for the 4-input combinational circuit L (Z = ~(A^B) | ~(C&D)). It drives the circuit under test (CUT) with all 16 input vectors in turn. For each vector it samples the CUT output, compares it with an internal golden copy of circuit L, and records a per-vector fail map, a mismatch count and the first failing vector. It sits between the stimulus side (the A, B, C, D pins) and the response side (Z) of the CUT, on the opposite end from the circuit itself.

## Interface
- SETTLE, default 2: number of idle cycles between driving a vector and sampling z_in. Legal range 0..15.
- clk  in  1  single clock; all state changes on the rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to begin a test run; honoured only in IDLE
- vec_out  out  4  vector driven to the CUT, {A,B,C,D} = vec_out[3:0] (A is MSB)
- z_in  in  1  CUT output Z
- busy  out  1  high while a run is in progress
- done  out  1  one-cycle pulse when a run completes
- pass  out  1  high when the last completed run had zero mismatches
- err_count  out  5  number of mismatching vectors, 0..16
- fail_map  out  16  bit i set when vector i mismatched
- first_fail  out  4  index of the lowest mismatching vector
- first_fail_valid  out  1  high when first_fail holds a real value

## Operation
- The golden model is computed internally and combinationally: g(v) = ~(v[3]^v[2]) | ~(v[1]&v[0]). g is 0 only for v = 7 (0111) and v = 11 (1011).
- States and transitions:
  - IDLE: start=1 → DRIVE, with idx=0, cnt=0, and err_count, fail_map, first_fail and first_fail_valid all cleared. pass is also cleared at run start.
  - DRIVE: vec_out=idx. While cnt<SETTLE, cnt increments. When cnt==SETTLE, go to SAMPLE.
  - SAMPLE: vec_out=idx. On a mismatch (z_in != g(idx)):
    - set fail_map[idx];
    - increment err_count;
    - if first_fail_valid=0, set first_fail=idx and first_fail_valid=1.
  - After SAMPLE: if idx==15 → DONE; otherwise idx increments, cnt=0, → DRIVE.
  - DONE: done=1 for this one cycle, pass=(err_count==0), then → IDLE.
- busy is 1 in DRIVE, SAMPLE and DONE, and 0 in IDLE.
- start is ignored outside IDLE. A start asserted in the same cycle as the DONE pulse is also ignored.
- In IDLE, vec_out holds the last applied vector (15 after a complete run). The result registers hold their values until the next start or reset.
- err_count cannot overflow: at most 16 increments into 5 bits.
- Reset mid-run aborts the run immediately and all state returns to reset values. No done pulse is produced.

## Timing
- Reset values: state=IDLE, vec_out=0, busy=0, done=0, pass=0, err_count=0, fail_map=0, first_fail=0, first_fail_valid=0.
- start is sampled at edge T0. From the cycle after T0, busy=1 and vec_out=0.
- Each vector takes SETTLE+1 cycles in DRIVE followed by 1 cycle in SAMPLE, i.e. SETTLE+2 cycles per vector.
- z_in is compared in the SAMPLE cycle. Vector v is therefore held for SETTLE+1 cycles before it is sampled.
- The DONE cycle starts 16*(SETTLE+2) cycles after T0+1. With SETTLE=2, that is 64 cycles.
- Results become visible when the state register updates after each sample. pass is valid from the DONE cycle onward.
- Each run produces exactly one done pulse.

## Test plan
- Fault-free CUT (z_in = g(vec_out)), SETTLE=2 → done after 64 cycles, pass=1, err_count=0, fail_map=16'h0000, first_fail_valid=0.
- Z stuck-at-0 → err_count=14, fail_map=16'hF77F, first_fail=0, pass=0.
- Z stuck-at-1, or net_e stuck-at-0 (Z stuck at 1 in both cases) → err_count=2, fail_map=16'h0880, first_fail=7.
- net_f stuck-at-1 (z_in = ~(A^B)) → err_count=6, fail_map=16'h0770, first_fail=4.
- start pulsed mid-run, and rst pulsed during vector 9 → the mid-run start has no effect. The rst returns all outputs to reset values the next cycle with no done pulse. A new start afterwards gives the fault-free results.
- SETTLE=0 with the fault-free CUT → done 32 cycles after start. Back-to-back runs with a Z stuck-at-1 CUT → the second run reports fail_map=16'h0880 with no carry-over from the first.

Source files
------------

// File: rtl/atpg_tester.sv
`default_nettype none
// ============================================================================
// Module   : atpg_tester
// Brief    : Exhaustive stuck-at test controller for Z = ~(A^B) | ~(C&D).
//            Applies all 16 vectors, compares Z with a golden copy and
//            records a fail map, mismatch count and first failing vector.
// Revision : 1.0 - initial release
// ============================================================================
module atpg_tester #(
    parameter int SETTLE = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [3:0]  vec_out,
    input  logic        z_in,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [4:0]  err_count,
    output logic [15:0] fail_map,
    output logic [3:0]  first_fail,
    output logic        first_fail_valid
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DRIVE  = 2'd1;
    localparam logic [1:0] S_SAMPLE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [3:0] c_settle   = 4'(SETTLE);
    localparam logic [3:0] c_last_idx = 4'd15;

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;
    logic [3:0]  r_idx;
    logic [3:0]  r_cnt;
    logic [4:0]  r_err;
    logic [15:0] r_fail_map;
    logic [3:0]  r_first_fail;
    logic        r_ffv;
    logic        r_pass;
    logic        w_golden;
    logic        w_mismatch;

    assign w_golden   = ~(r_idx[3] ^ r_idx[2]) | ~(r_idx[1] & r_idx[0]);
    assign w_mismatch = (r_state == S_SAMPLE) && (z_in != w_golden);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next_state = S_DRIVE;
            S_DRIVE:  if (r_cnt == c_settle) w_next_state = S_SAMPLE;
            S_SAMPLE: w_next_state = (r_idx == c_last_idx) ? S_DONE : S_DRIVE;
            S_DONE:   w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx        <= 4'd0;
            r_cnt        <= 4'd0;
            r_err        <= 5'd0;
            r_fail_map   <= 16'd0;
            r_first_fail <= 4'd0;
            r_ffv        <= 1'b0;
            r_pass       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_idx        <= 4'd0;
                        r_cnt        <= 4'd0;
                        r_err        <= 5'd0;
                        r_fail_map   <= 16'd0;
                        r_first_fail <= 4'd0;
                        r_ffv        <= 1'b0;
                        r_pass       <= 1'b0;
                    end
                end
                S_DRIVE: begin
                    if (r_cnt != c_settle) r_cnt <= r_cnt + 4'd1;
                end
                S_SAMPLE: begin
                    if (w_mismatch) begin
                        r_fail_map[r_idx] <= 1'b1;
                        r_err             <= r_err + 5'd1;
                        if (!r_ffv) begin
                            r_first_fail <= r_idx;
                            r_ffv        <= 1'b1;
                        end
                    end
                    // pass is registered here so it is already valid in the DONE cycle
                    if (r_idx == c_last_idx) begin
                        r_pass <= (r_err == 5'd0) && !w_mismatch;
                    end else begin
                        r_idx <= r_idx + 4'd1;
                        r_cnt <= 4'd0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign vec_out          = r_idx;
    assign busy             = (r_state != S_IDLE);
    assign done             = (r_state == S_DONE);
    assign pass             = r_pass;
    assign err_count        = r_err;
    assign fail_map         = r_fail_map;
    assign first_fail       = r_first_fail;
    assign first_fail_valid = r_ffv;

endmodule
`default_nettype wire
